// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: funnels per-LSU read/write requests onto NUM_CHANNELS
// memory ports. Each channel claims one consumer, runs the memory handshake,
// relays the response and releases the consumer once it drops valid.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// IDLE           | scanning consumers, lowest index first, reads before writes
// READ_WAITING   | mem_read_valid held, waiting for mem_read_ready
// WRITE_WAITING  | mem_write_valid held, waiting for mem_write_ready
// READ_RELAYING  | consumer_read_ready held until consumer drops read valid
// WRITE_RELAYING | consumer_write_ready held until consumer drops write valid
module lsu_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } state_t;

  state_t                           state_q [NUM_CHANNELS];
  state_t                           state_d [NUM_CHANNELS];
  logic [CW-1:0]                    cur_q   [NUM_CHANNELS];
  logic [CW-1:0]                    cur_d   [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]         claimed_q, claimed_d, taken;
  logic [NUM_CONSUMERS-1:0]         rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [NUM_CHANNELS-1:0]          mrv_q, mrv_d, mwv_q, mwv_d;
  logic [NUM_CHANNELS*ADDR_BITS-1:0] mra_q, mra_d, mwa_q, mwa_d;
  logic [NUM_CHANNELS*DATA_BITS-1:0] mwd_q, mwd_d;
  logic                             found;
  int                               sel;

  // Next-state logic: channels are evaluated in order so a consumer claimed by
  // a lower channel this cycle is already marked taken for higher channels.
  // A consumer released this cycle stays taken until the next edge.
  always_comb begin
    claimed_d  = claimed_q;
    taken      = claimed_q;
    rd_ready_d = rd_ready_q;
    wr_ready_d = wr_ready_q;
    rd_data_d  = rd_data_q;
    mrv_d      = mrv_q;
    mra_d      = mra_q;
    mwv_d      = mwv_q;
    mwa_d      = mwa_q;
    mwd_d      = mwd_q;
    found      = 1'b0;
    sel        = 0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      cur_d[ch]   = cur_q[ch];
      case (state_q[ch])
        IDLE: begin
          found = 1'b0;
          sel   = 0;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!found && !taken[i] &&
                (consumer_read_valid[i] || ((WRITE_ENABLE != 0) && consumer_write_valid[i]))) begin
              found = 1'b1;
              sel   = i;
            end
          end
          if (found) begin
            taken[sel]     = 1'b1;
            claimed_d[sel] = 1'b1;
            cur_d[ch]      = CW'(sel);
            if (consumer_read_valid[sel]) begin
              mrv_d[ch] = 1'b1;
              mra_d[ch*ADDR_BITS +: ADDR_BITS] = consumer_read_address[sel*ADDR_BITS +: ADDR_BITS];
              state_d[ch] = READ_WAITING;
            end else begin
              mwv_d[ch] = 1'b1;
              mwa_d[ch*ADDR_BITS +: ADDR_BITS] = consumer_write_address[sel*ADDR_BITS +: ADDR_BITS];
              mwd_d[ch*DATA_BITS +: DATA_BITS] = consumer_write_data[sel*DATA_BITS +: DATA_BITS];
              state_d[ch] = WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            mrv_d[ch] = 1'b0;
            rd_data_d[int'(cur_q[ch])*DATA_BITS +: DATA_BITS] = mem_read_data[ch*DATA_BITS +: DATA_BITS];
            rd_ready_d[cur_q[ch]] = 1'b1;
            state_d[ch] = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            mwv_d[ch] = 1'b0;
            wr_ready_d[cur_q[ch]] = 1'b1;
            state_d[ch] = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[cur_q[ch]]) begin
            rd_ready_d[cur_q[ch]] = 1'b0;
            claimed_d[cur_q[ch]]  = 1'b0;
            state_d[ch] = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[cur_q[ch]]) begin
            wr_ready_d[cur_q[ch]] = 1'b0;
            claimed_d[cur_q[ch]]  = 1'b0;
            state_d[ch] = IDLE;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        cur_q[ch]   <= '0;
      end
      claimed_q  <= '0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
      mrv_q      <= '0;
      mra_q      <= '0;
      mwv_q      <= '0;
      mwa_q      <= '0;
      mwd_q      <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= state_d[ch];
        cur_q[ch]   <= cur_d[ch];
      end
      claimed_q  <= claimed_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q  <= rd_data_d;
      mrv_q      <= mrv_d;
      mra_q      <= mra_d;
      mwv_q      <= mwv_d;
      mwa_q      <= mwa_d;
      mwd_q      <= mwd_d;
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_read_data   = rd_data_q;
  assign mem_read_valid       = mrv_q;
  assign mem_read_address     = mra_q;
  assign consumer_write_ready = (WRITE_ENABLE != 0) ? wr_ready_q : '0;
  assign mem_write_valid      = (WRITE_ENABLE != 0) ? mwv_q : '0;
  assign mem_write_address    = (WRITE_ENABLE != 0) ? mwa_q : '0;
  assign mem_write_data       = (WRITE_ENABLE != 0) ? mwd_q : '0;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: per-cycle vector table on a 1-channel instance,
// plus a hand-written parallel-claim sequence on a 2-channel instance.
module tb_lsu_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 1-channel instance
  logic [3:0]  rv, wv, crr, cwr;
  logic [31:0] ra, wa, wd, crd;
  logic [0:0]  mrv, mrr, mwv, mwr;
  logic [7:0]  mra, mrd, mwa, mwd;

  lsu_mem_arbiter #(.NUM_CHANNELS(1)) dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  // 2-channel instance
  logic [3:0]  rv2, crr2, cwr2;
  logic [31:0] ra2, crd2;
  logic [1:0]  mrv2, mrr2, mwv2, mwr2;
  logic [15:0] mra2, mrd2, mwa2, mwd2;

  lsu_mem_arbiter #(.NUM_CHANNELS(2)) dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv2), .consumer_read_address(ra2),
    .consumer_read_ready(crr2), .consumer_read_data(crd2),
    .consumer_write_valid(4'b0), .consumer_write_address(32'h0),
    .consumer_write_data(32'h0), .consumer_write_ready(cwr2),
    .mem_read_valid(mrv2), .mem_read_address(mra2),
    .mem_read_ready(mrr2), .mem_read_data(mrd2),
    .mem_write_valid(mwv2), .mem_write_address(mwa2),
    .mem_write_data(mwd2), .mem_write_ready(mwr2)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [31:0] ra;
    logic [3:0]  wv;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        mrr;
    logic [7:0]  mrd;
    logic        mwr;
    logic [65:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [65:0] ex(logic emrv, logic [7:0] emra, logic emwv,
                                     logic [7:0] emwa, logic [7:0] emwd, logic [3:0] ecrr,
                                     logic [31:0] ecrd, logic [3:0] ecwr);
    return {emrv, emra, emwv, emwa, emwd, ecrr, ecrd, ecwr};
  endfunction

  function automatic void add(logic r, logic [3:0] v_rv, logic [31:0] v_ra,
                              logic [3:0] v_wv, logic [31:0] v_wa, logic [31:0] v_wd,
                              logic v_mrr, logic [7:0] v_mrd, logic v_mwr, logic [65:0] e);
    vec_t v;
    v.rst = r; v.rv = v_rv; v.ra = v_ra; v.wv = v_wv; v.wa = v_wa; v.wd = v_wd;
    v.mrr = v_mrr; v.mrd = v_mrd; v.mwr = v_mwr; v.exp = e;
    vecs.push_back(v);
  endfunction

  logic [65:0] act;
  logic [53:0] act2, exp2;

  task automatic check2(string name, logic [53:0] e);
    act2 = {mrv2, mra2, crr2, crd2};
    n_vec++;
    if (act2 !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act2, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    rv = '0; ra = '0; wv = '0; wa = '0; wd = '0; mrr = '0; mrd = '0; mwr = '0;
    rv2 = '0; ra2 = '0; mrr2 = '0; mrd2 = '0; mwr2 = '0;

    //   rst rv       ra            wv       wa            wd            mrr mrd    mwr  expected {mrv mra mwv mwa mwd crr crd cwr}
    add(1, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(0, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 32'h00000000, 4'b0000));
    // single read: consumer 2, addr 0x1A, data 0x5C
    add(0, 4'b0100, 32'h001A0000, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(1, 8'h1A, 0, 8'h00, 8'h00, 4'b0000, 32'h00000000, 4'b0000));
    add(0, 4'b0100, 32'h001A0000, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(1, 8'h1A, 0, 8'h00, 8'h00, 4'b0000, 32'h00000000, 4'b0000));
    add(0, 4'b0100, 32'h001A0000, 4'b0000, 32'h0,        32'h0,        1, 8'h5C, 0, ex(0, 8'h1A, 0, 8'h00, 8'h00, 4'b0100, 32'h005C0000, 4'b0000));
    add(0, 4'b0100, 32'h001A0000, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(0, 8'h1A, 0, 8'h00, 8'h00, 4'b0100, 32'h005C0000, 4'b0000));
    add(0, 4'b0000, 32'h001A0000, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(0, 8'h1A, 0, 8'h00, 8'h00, 4'b0000, 32'h005C0000, 4'b0000));
    add(0, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(0, 8'h1A, 0, 8'h00, 8'h00, 4'b0000, 32'h005C0000, 4'b0000));
    // contention: consumers 0 (0x10) and 3 (0x30); stray mem ready in relaying ignored
    add(0, 4'b1001, 32'h30000010, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(1, 8'h10, 0, 8'h00, 8'h00, 4'b0000, 32'h005C0000, 4'b0000));
    add(0, 4'b1001, 32'h30000010, 4'b0000, 32'h0,        32'h0,        1, 8'h11, 0, ex(0, 8'h10, 0, 8'h00, 8'h00, 4'b0001, 32'h005C0011, 4'b0000));
    add(0, 4'b1000, 32'h30000010, 4'b0000, 32'h0,        32'h0,        1, 8'hEE, 0, ex(0, 8'h10, 0, 8'h00, 8'h00, 4'b0000, 32'h005C0011, 4'b0000));
    add(0, 4'b1000, 32'h30000010, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(1, 8'h30, 0, 8'h00, 8'h00, 4'b0000, 32'h005C0011, 4'b0000));
    add(0, 4'b1000, 32'h30000010, 4'b0000, 32'h0,        32'h0,        1, 8'h33, 0, ex(0, 8'h30, 0, 8'h00, 8'h00, 4'b1000, 32'h335C0011, 4'b0000));
    add(0, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(0, 8'h30, 0, 8'h00, 8'h00, 4'b0000, 32'h335C0011, 4'b0000));
    // write: consumer 0 writes 0xAB to 0x07; later input changes ignored
    add(0, 4'b0000, 32'h0,        4'b0001, 32'h00000007, 32'h000000AB, 0, 8'h00, 0, ex(0, 8'h30, 1, 8'h07, 8'hAB, 4'b0000, 32'h335C0011, 4'b0000));
    add(0, 4'b0000, 32'h0,        4'b0001, 32'h000000FF, 32'h00000000, 0, 8'h00, 0, ex(0, 8'h30, 1, 8'h07, 8'hAB, 4'b0000, 32'h335C0011, 4'b0000));
    add(0, 4'b0000, 32'h0,        4'b0001, 32'h000000FF, 32'h00000000, 0, 8'h00, 1, ex(0, 8'h30, 0, 8'h07, 8'hAB, 4'b0000, 32'h335C0011, 4'b0001));
    add(0, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(0, 8'h30, 0, 8'h07, 8'hAB, 4'b0000, 32'h335C0011, 4'b0000));
    // priority: consumer 1 read 0x44 and write 0x66 to 0x55
    add(0, 4'b0010, 32'h00004400, 4'b0010, 32'h00005500, 32'h00006600, 0, 8'h00, 0, ex(1, 8'h44, 0, 8'h07, 8'hAB, 4'b0000, 32'h335C0011, 4'b0000));
    add(0, 4'b0010, 32'h00004400, 4'b0010, 32'h00005500, 32'h00006600, 1, 8'h77, 0, ex(0, 8'h44, 0, 8'h07, 8'hAB, 4'b0010, 32'h335C7711, 4'b0000));
    add(0, 4'b0000, 32'h00004400, 4'b0010, 32'h00005500, 32'h00006600, 0, 8'h00, 0, ex(0, 8'h44, 0, 8'h07, 8'hAB, 4'b0000, 32'h335C7711, 4'b0000));
    add(0, 4'b0000, 32'h0,        4'b0010, 32'h00005500, 32'h00006600, 0, 8'h00, 0, ex(0, 8'h44, 1, 8'h55, 8'h66, 4'b0000, 32'h335C7711, 4'b0000));
    add(0, 4'b0000, 32'h0,        4'b0010, 32'h00005500, 32'h00006600, 0, 8'h00, 1, ex(0, 8'h44, 0, 8'h55, 8'h66, 4'b0000, 32'h335C7711, 4'b0010));
    add(0, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(0, 8'h44, 0, 8'h55, 8'h66, 4'b0000, 32'h335C7711, 4'b0000));
    // reset mid-read, then the same request completes normally
    add(0, 4'b0001, 32'h00000021, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(1, 8'h21, 0, 8'h55, 8'h66, 4'b0000, 32'h335C7711, 4'b0000));
    add(1, 4'b0001, 32'h00000021, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(0, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 32'h00000000, 4'b0000));
    add(0, 4'b0001, 32'h00000021, 4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(1, 8'h21, 0, 8'h00, 8'h00, 4'b0000, 32'h00000000, 4'b0000));
    add(0, 4'b0001, 32'h00000021, 4'b0000, 32'h0,        32'h0,        1, 8'h99, 0, ex(0, 8'h21, 0, 8'h00, 8'h00, 4'b0001, 32'h00000099, 4'b0000));
    add(0, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 8'h00, 0, ex(0, 8'h21, 0, 8'h00, 8'h00, 4'b0000, 32'h00000099, 4'b0000));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      rv = vecs[i].rv; ra = vecs[i].ra; wv = vecs[i].wv; wa = vecs[i].wa; wd = vecs[i].wd;
      mrr = vecs[i].mrr; mrd = vecs[i].mrd; mwr = vecs[i].mwr;
      @(posedge clk);
      #1;
      act = {mrv, mra, mwv, mwa, mwd, crr, crd, cwr};
      n_vec++;
      if (act !== vecs[i].exp) begin
        n_bad++;
        $display("FAIL vec%0d: got %h expected %h", i, act, vecs[i].exp);
      end
    end

    // 2 channels: consumers 1 (0x11) and 2 (0x22) claimed in the same cycle
    @(negedge clk);
    reset = 1'b0;
    rv2 = 4'b0110; ra2 = 32'h00221100;
    @(posedge clk); #1;
    exp2 = {2'b11, 16'h2211, 4'b0000, 32'h00000000};
    check2("par_claim", exp2);
    @(negedge clk);
    mrr2 = 2'b11; mrd2 = 16'hB2A1;
    @(posedge clk); #1;
    exp2 = {2'b00, 16'h2211, 4'b0110, 32'h00B2A100};
    check2("par_done", exp2);
    @(negedge clk);
    mrr2 = 2'b00; rv2 = 4'b0000;
    @(posedge clk); #1;
    exp2 = {2'b00, 16'h2211, 4'b0000, 32'h00B2A100};
    check2("par_release", exp2);
    // three requesters, two channels: consumers 0 and 1 win, 2 waits
    @(negedge clk);
    rv2 = 4'b0111; ra2 = 32'h00CCBBAA;
    @(posedge clk); #1;
    exp2 = {2'b11, 16'hBBAA, 4'b0000, 32'h00B2A100};
    check2("par_three", exp2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
